// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// func encodings, FSM state enum and per-width iteration counts.
package muldiv_seq_pkg;

    localparam logic [1:0] MD_MUL  = 2'b00;
    localparam logic [1:0] MD_IMUL = 2'b01;
    localparam logic [1:0] MD_DIV  = 2'b10;
    localparam logic [1:0] MD_IDIV = 2'b11;

    localparam int unsigned N_WORD = 16;
    localparam int unsigned N_BYTE = 8;
    localparam int unsigned CNT_W  = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX,
        S_DONE
    } state_e;

endpackage

// File: rtl/muldiv_seq_negabs.sv
// md_negabs: conditional two's-complement negate, 32 bits wide.
//   i_a   - operand
//   i_neg - 1 = output -i_a, 0 = pass i_a through
//   o_y   - result
module md_negabs (
    input  logic [31:0] i_a,
    input  logic        i_neg,
    output logic [31:0] o_y
);

    assign o_y = i_neg ? (32'd0 - i_a) : i_a;

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: one-bit-per-clock shift-add multiply / restoring divide for
// the ALU mul/div slot (8- and 16-bit operand sizes, signed and unsigned).
//   clk, rst        - clock, async active-low reset
//   start           - request, sampled only in IDLE
//   x, y            - operands (x: multiplicand / dividend, y: multiplier / divisor)
//   func, word_op   - operation select and operand size
//   out, cfo, ofo   - result and multiply overflow flags, valid with done
//   busy, done, exc - in-progress, completion pulse, divide error
module muldiv_seq
    import muldiv_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] x,
    input  logic [15:0] y,
    input  logic [1:0]  func,
    input  logic        word_op,
    output logic [31:0] out,
    output logic        cfo,
    output logic        ofo,
    output logic        busy,
    output logic        done,
    output logic        exc
);

    state_e             r_state, w_state_nxt;
    logic [31:0]        r_x, r_acc, r_out;
    logic [15:0]        r_y, r_mc;
    logic [1:0]         r_func;
    logic               r_word, r_qneg, r_rneg;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_cfo, r_ofo, r_exc, r_done, r_busy;

    logic [31:0]        w_na_in, w_na_out, w_nb_in, w_nb_out;
    logic               w_na_neg, w_nb_neg;
    logic               w_prep_exc;
    logic [31:0]        w_prep_acc, w_run_acc, w_fix_out;
    logic [15:0]        w_prep_mc;
    logic               w_fix_exc, w_fix_cf;
    logic [16:0]        w_msum17, w_dhi17;
    logic [8:0]         w_msum9, w_dhi9;
    logic [15:0]        w_dtr16;
    logic [7:0]         w_dtr8;
    logic [31:0]        w_out_nxt;
    logic               w_cfo_nxt, w_ofo_nxt, w_exc_nxt, w_done_nxt, w_busy_nxt;

    md_negabs u_neg_a (.i_a(w_na_in), .i_neg(w_na_neg), .o_y(w_na_out));
    md_negabs u_neg_b (.i_a(w_nb_in), .i_neg(w_nb_neg), .o_y(w_nb_out));

    // Negator inputs: operand magnitudes in PREP, sign restore in FIX.
    always_comb begin
        w_na_in  = '0;
        w_na_neg = 1'b0;
        w_nb_in  = '0;
        w_nb_neg = 1'b0;
        if (r_state == S_PREP) begin
            if (r_func[1])
                w_na_in = r_word ? r_x : {{16{r_x[15]}}, r_x[15:0]};
            else
                w_na_in = r_word ? {{16{r_x[15]}}, r_x[15:0]} : {{24{r_x[7]}}, r_x[7:0]};
            w_nb_in  = r_word ? {{16{r_y[15]}}, r_y} : {{24{r_y[7]}}, r_y[7:0]};
            w_na_neg = r_func[0] & w_na_in[31];
            w_nb_neg = r_func[0] & w_nb_in[31];
        end else if (r_state == S_FIX) begin
            if (r_func[1]) begin
                w_na_in  = r_word ? {16'd0, r_acc[15:0]}  : {24'd0, r_acc[7:0]};
                w_nb_in  = r_word ? {16'd0, r_acc[31:16]} : {24'd0, r_acc[15:8]};
                w_nb_neg = r_rneg;
            end else begin
                w_na_in = r_acc;
            end
            w_na_neg = r_qneg;
        end
    end

    // PREP: zero divisor, and magnitude quotient that cannot fit N bits.
    always_comb begin
        w_prep_exc = 1'b0;
        if (r_func[1]) begin
            if (w_nb_out == 32'd0)
                w_prep_exc = 1'b1;
            else if (r_word)
                w_prep_exc = (w_na_out[31:16] >= w_nb_out[15:0]);
            else
                w_prep_exc = (w_na_out[15:8] >= w_nb_out[7:0]);
        end
        if (r_func[1]) begin
            w_prep_acc = r_word ? w_na_out : {16'd0, w_na_out[15:0]};
            w_prep_mc  = w_nb_out[15:0];
        end else begin
            w_prep_acc = r_word ? {16'd0, w_nb_out[15:0]} : {24'd0, w_nb_out[7:0]};
            w_prep_mc  = w_na_out[15:0];
        end
    end

    // RUN: one multiply or divide step on the accumulator.
    always_comb begin
        w_msum17 = {1'b0, r_acc[31:16]} + (r_acc[0] ? {1'b0, r_mc} : 17'd0);
        w_msum9  = {1'b0, r_acc[15:8]} + (r_acc[0] ? {1'b0, r_mc[7:0]} : 9'd0);
        w_dhi17  = r_acc[31:15];
        w_dhi9   = r_acc[15:7];
        w_dtr16  = w_dhi17[15:0] - r_mc;
        w_dtr8   = w_dhi9[7:0] - r_mc[7:0];
        if (!r_func[1])
            w_run_acc = r_word ? {w_msum17, r_acc[15:1]} : {16'd0, w_msum9, r_acc[7:1]};
        else if (r_word)
            w_run_acc = (w_dhi17 >= {1'b0, r_mc}) ? {w_dtr16, r_acc[14:0], 1'b1}
                                                  : {r_acc[30:0], 1'b0};
        else
            w_run_acc = (w_dhi9 >= {1'b0, r_mc[7:0]}) ? {16'd0, w_dtr8, r_acc[6:0], 1'b1}
                                                      : {16'd0, r_acc[14:0], 1'b0};
    end

    // FIX: signed result, overflow flags, signed-quotient range error.
    always_comb begin
        w_fix_exc = (r_func == MD_IDIV) && (r_word ? r_acc[15] : r_acc[7]);
        w_fix_cf  = 1'b0;
        w_fix_out = '0;
        if (!r_func[1]) begin
            if (r_word) begin
                w_fix_out = w_na_out;
                w_fix_cf  = r_func[0] ? (w_na_out[31:16] != {16{w_na_out[15]}})
                                      : (w_na_out[31:16] != 16'd0);
            end else begin
                w_fix_out = {16'd0, w_na_out[15:0]};
                w_fix_cf  = r_func[0] ? (w_na_out[15:8] != {8{w_na_out[7]}})
                                      : (w_na_out[15:8] != 8'd0);
            end
        end else if (!w_fix_exc) begin
            w_fix_out = r_word ? {w_nb_out[15:0], w_na_out[15:0]}
                               : {16'd0, w_nb_out[7:0], w_na_out[7:0]};
        end
    end

    // FSM next state and next registered outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = r_out;
        w_cfo_nxt   = r_cfo;
        w_ofo_nxt   = r_ofo;
        w_exc_nxt   = r_exc;
        w_done_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_PREP;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_PREP: begin
                if (w_prep_exc) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                    w_exc_nxt   = 1'b1;
                    w_out_nxt   = '0;
                    w_cfo_nxt   = 1'b0;
                    w_ofo_nxt   = 1'b0;
                end else begin
                    w_state_nxt = S_RUN;
                    w_busy_nxt  = 1'b1;
                end
            end
            S_RUN: begin
                w_busy_nxt = 1'b1;
                if (r_cnt == CNT_W'(1))
                    w_state_nxt = S_FIX;
            end
            S_FIX: begin
                w_state_nxt = S_DONE;
                w_done_nxt  = 1'b1;
                w_out_nxt   = w_fix_out;
                w_exc_nxt   = w_fix_exc;
                w_cfo_nxt   = w_fix_cf;
                w_ofo_nxt   = w_fix_cf;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out  <= '0;
            r_cfo  <= 1'b0;
            r_ofo  <= 1'b0;
            r_exc  <= 1'b0;
            r_done <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_out  <= w_out_nxt;
            r_cfo  <= w_cfo_nxt;
            r_ofo  <= w_ofo_nxt;
            r_exc  <= w_exc_nxt;
            r_done <= w_done_nxt;
            r_busy <= w_busy_nxt;
        end
    end

    // Operand latches, accumulator, counter and sign bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x    <= '0;
            r_y    <= '0;
            r_func <= MD_MUL;
            r_word <= 1'b0;
            r_acc  <= '0;
            r_mc   <= '0;
            r_cnt  <= '0;
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x    <= x;
                        r_y    <= y;
                        r_func <= func;
                        r_word <= word_op;
                    end
                end
                S_PREP: begin
                    r_acc  <= w_prep_acc;
                    r_mc   <= w_prep_mc;
                    r_cnt  <= r_word ? CNT_W'(N_WORD) : CNT_W'(N_BYTE);
                    r_qneg <= w_na_neg ^ w_nb_neg;
                    r_rneg <= w_na_neg;
                end
                S_RUN: begin
                    r_acc <= w_run_acc;
                    r_cnt <= r_cnt - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign out  = r_out;
    assign cfo  = r_cfo;
    assign ofo  = r_ofo;
    assign exc  = r_exc;
    assign done = r_done;
    assign busy = r_busy;

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer for the ALU's mul/div slot (t=3). It takes `x`/`y` operands in the ALU's operand format and runs a shift-add multiply or a restoring divide, one bit per clock. It returns the 32-bit result and the cf/of flags in the layout the ALU output mux expects. The microcode sequencer holds the instruction on `busy` and raises INT 0 on `exc`.

## Interface
- No parameters; widths are fixed by the 8086 operand sizes.
- `clk` — in — 1 — rising-edge clock.
- `rst` — in — 1 — asynchronous, active-low reset.
- `start` — in — 1 — one-cycle request; sampled only in IDLE.
- `x` — in — 32 — multiply: multiplicand in [15:0]. Divide: dividend, word {DX,AX}, byte uses [15:0].
- `y` — in — 16 — multiplier/divisor; byte ops use [7:0].
- `func` — in — 2 — 00 mul, 01 imul, 10 div, 11 idiv.
- `word_op` — in — 1 — 1 = 16-bit operation, 0 = 8-bit.
- `out` — out — 32 — result; held until the next accepted `start`.
- `cfo`, `ofo` — out — 1 each — multiply overflow flags; 0 for divide.
- `busy` — out — 1 — high from the cycle after `start` through the cycle before `done`.
- `done` — out — 1 — one-cycle pulse; `out`/`cfo`/`ofo`/`exc` are valid in that cycle.
- `exc` — out — 1 — divide error (zero divisor or quotient overflow); valid with `done`.

## Operation
- **FSM:** IDLE → PREP → RUN → FIX → DONE → IDLE.
- **IDLE:** `start`=1 latches `x`, `y`, `func`, `word_op`.
- **PREP:**
  - Signed ops (`func[0]`=1) take operand magnitudes; record result sign and dividend sign.
  - Zero divisor → `exc`, jump straight to DONE.
  - Unsigned div overflow: high dividend half ≥ divisor → `exc`, go to DONE. High half is `x[31:16]` (word) or `x[15:8]` (byte).
  - Otherwise load the iteration counter with N = 16 (word) or 8 (byte).
- **RUN:**
  - Multiply: conditional add of the multiplicand, then shift right into a 2N-bit accumulator.
  - Divide: shift the remainder left, trial-subtract, set the quotient bit.
  - The counter decrements each cycle; leave RUN when the counter reaches 1.
- **FIX:**
  - Apply signs: product is negated if signs differ; quotient is negated if signs differ; remainder takes the dividend's sign.
  - Signed quotient magnitude > 2^(N-1)−1 → `exc` (8086 behaviour).
- **Output layout:**
  - Multiply word: `out` = 32-bit product.
  - Multiply byte: `out` = {16'd0, 16-bit product}.
  - Divide word: `out` = {rem16, quot16}.
  - Divide byte: `out` = {16'd0, rem8, quot8}.
  - On `exc`, `out` = 0.
- **Flags:**
  - mul: `cfo`=`ofo`=(upper half ≠ 0).
  - imul: `cfo`=`ofo`=(upper half ≠ sign extension of lower half).
- **Reset:** all outputs 0, state IDLE, from any state (including mid-RUN). No partial result survives.
- `start` while not in IDLE is ignored; no queuing.

## Timing
- `start` high in cycle 0 → PREP in cycle 1 → RUN in cycles 2..N+1 → FIX in cycle N+2 → `done` in cycle N+3.
- Latency: word 19 cycles, byte 11 cycles.
- PREP-detected exceptions: `done`=`exc`=1 in cycle 2.
- `busy` is high in cycles 1..N+2 (1 on PREP exception); `busy` and `done` are never high together.
- A new `start` is accepted no earlier than the cycle after `done`.

## Structure
- Shared package holds:
  - the `func` encodings (MD_MUL, MD_IMUL, MD_DIV, MD_IDIV);
  - the FSM state enum;
  - the iteration counts 16 and 8.
- One sub-module, `md_negabs`: combinational conditional two's-complement negate, 32-bit wide. It is used in PREP (magnitude) and in FIX (sign restore).
- The datapath registers (accumulator, counter, sign bits) and the FSM live in the top level.

## Test plan
- **Unsigned word mul:** mul word, `x`=0x1234, `y`=0x0100 → `out`=0x00123400, `cfo`=`ofo`=1, `done` in cycle 19.
- **Signed byte mul:** imul byte, `x[7:0]`=0xFE, `y`=0x03 → `out`=0x0000FFFA, `cfo`=`ofo`=0, `done` in cycle 11.
- **Unsigned word div:** div word, `x`=0x00010005, `y`=0x0002 → `out`=0x00018002, `exc`=0.
- **Signed word div:** idiv word, `x`=0xFFFFFFF9, `y`=0x0002 → `out`=0xFFFFFFFD (rem −1, quot −3), `exc`=0.
- **Divide errors:**
  - div word, `y`=0 → `done`=`exc`=1 in cycle 2, `out`=0.
  - div byte, `x`=0x0100, `y`=0x01 → `exc` in cycle 2.
  - idiv byte, `x`=0x0080, `y`=0x01 → `exc` in cycle 11.
- **Reset and busy rules:**
  - Assert `rst` low in cycle 5 of a word div → all outputs 0 at once; no `done`.
  - A `start` during `busy` is ignored, and the original result still completes unchanged.
